// File: rtl/spi_dac_tx.sv
// spi_dac_tx: SPI mode-0 transmitter for a 16-bit DAC frame {cmd, data} with
// chip-select setup/gap timing and a one-cycle ldac_n latch strobe.
module spi_dac_tx #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_GAP   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tx_valid,
   output logic        tx_ready,
   input  logic [3:0]  tx_cmd,
   input  logic [11:0] tx_data,
   output logic        busy,
   output logic        done,
   output logic        sclk,
   output logic        cs_n,
   output logic        mosi,
   output logic        ldac_n
);
   localparam int MAX_SG = (CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP;
   localparam int MAXC   = (CLK_DIV > MAX_SG) ? CLK_DIV : MAX_SG;
   localparam int CW     = $clog2(MAXC + 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [3:0]    bit_q;
   logic [15:0]   sr_q;
   logic          ready_q, busy_q, done_q, sclk_q, cs_n_q, mosi_q, ldac_n_q;

   assign tx_ready = ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign sclk     = sclk_q;
   assign cs_n     = cs_n_q;
   assign mosi     = mosi_q;
   assign ldac_n   = ldac_n_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         sr_q     <= '0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sclk_q   <= 1'b0;
         cs_n_q   <= 1'b1;
         mosi_q   <= 1'b0;
         ldac_n_q <= 1'b1;
      end else begin
         done_q   <= 1'b0;
         ldac_n_q <= 1'b1;
         case (state_q)
            IDLE: if (tx_valid) begin
               sr_q    <= {tx_cmd, tx_data};
               mosi_q  <= tx_cmd[3];
               cs_n_q  <= 1'b0;
               ready_q <= 1'b0;
               busy_q  <= 1'b1;
               cnt_q   <= '0;
               bit_q   <= '0;
               state_q <= SETUP;
            end
            SETUP: if (cnt_q == CW'(CS_SETUP - 1)) begin
               cnt_q   <= '0;
               state_q <= SHIFT;
            end else cnt_q <= cnt_q + 1'b1;
            SHIFT: if (cnt_q == CW'(CLK_DIV - 1)) begin
               cnt_q  <= '0;
               sclk_q <= ~sclk_q;
               // Data advances only on the falling edge; zeros fill in behind the frame.
               if (sclk_q) begin
                  sr_q   <= {sr_q[14:0], 1'b0};
                  mosi_q <= sr_q[14];
                  bit_q  <= bit_q + 1'b1;
                  if (bit_q == 4'd15) state_q <= HOLD;
               end
            end else cnt_q <= cnt_q + 1'b1;
            HOLD: if (cnt_q == CW'(CLK_DIV - 1)) begin
               cnt_q    <= '0;
               cs_n_q   <= 1'b1;
               mosi_q   <= 1'b0;
               ldac_n_q <= 1'b0;
               state_q  <= GAP;
            end else cnt_q <= cnt_q + 1'b1;
            GAP: if (cnt_q == CW'(CS_GAP - 1)) begin
               cnt_q   <= '0;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end else cnt_q <= cnt_q + 1'b1;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_dac_tx.sv
// tb_spi_dac_tx: checks frame timing and SPI capture for a default-parameter
// instance and a fastest-setting instance (all timing parameters 1).
module tb_spi_dac_tx;
   logic clk = 1'b0, reset = 1'b0;
   logic v0 = 1'b0, v1 = 1'b0;
   logic [3:0] c0 = '0, c1 = '0;
   logic [11:0] d0 = '0, d1 = '0;
   logic rdy0, busy0, done0, sclk0, cs0, mosi0, ldac0;
   logic rdy1, busy1, done1, sclk1, cs1, mosi1, ldac1;
   logic sel = 1'b0;
   logic rdy_m, busy_m, done_m, sclk_m, cs_m, mosi_m, ldac_m;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   spi_dac_tx dut0 (.clk(clk), .reset(reset), .tx_valid(v0), .tx_ready(rdy0), .tx_cmd(c0),
      .tx_data(d0), .busy(busy0), .done(done0), .sclk(sclk0), .cs_n(cs0), .mosi(mosi0), .ldac_n(ldac0));
   spi_dac_tx #(.CLK_DIV(1), .CS_SETUP(1), .CS_GAP(1)) dut1 (.clk(clk), .reset(reset), .tx_valid(v1),
      .tx_ready(rdy1), .tx_cmd(c1), .tx_data(d1), .busy(busy1), .done(done1), .sclk(sclk1), .cs_n(cs1),
      .mosi(mosi1), .ldac_n(ldac1));

   assign rdy_m  = sel ? rdy1  : rdy0;
   assign busy_m = sel ? busy1 : busy0;
   assign done_m = sel ? done1 : done0;
   assign sclk_m = sel ? sclk1 : sclk0;
   assign cs_m   = sel ? cs1   : cs0;
   assign mosi_m = sel ? mosi1 : mosi0;
   assign ldac_m = sel ? ldac1 : ldac0;

   typedef struct {
      logic [15:0] w;
      bit          f;
      int          cs_low;
      int          done_at;
   } vec_t;
   vec_t vecs[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Frame timing from the parameter rules: cs_n low = setup + 33 half-periods;
   // done lands in the last cycle of a setup+33*div+gap+1 cycle period.
   function automatic vec_t mk(input logic [15:0] w, input bit f);
      int div = f ? 1 : 4, su = f ? 1 : 2, gp = f ? 1 : 2;
      mk.w = w;
      mk.f = f;
      mk.cs_low = su + 33 * div;
      mk.done_at = su + 33 * div + gp;
   endfunction

   // Called just after a negedge; accept happens at the following posedge.
   task automatic send(input vec_t v, input string nm);
      int n = 0, rises = 0, tog = 0, cslow = 0, ldacl = 0, bad = 0;
      logic [15:0] cap = '0;
      logic ps = 1'b0;
      bit got = 0;
      sel = v.f;
      chk({nm, " ready"}, {31'd0, rdy_m}, 32'd1);
      if (v.f) begin v1 = 1'b1; {c1, d1} = v.w; end
      else begin v0 = 1'b1; {c0, d0} = v.w; end
      @(negedge clk);
      v0 = 1'b0; v1 = 1'b0;
      {c0, d0} = 16'($urandom); {c1, d1} = 16'($urandom);
      while (!got && n < 600) begin
         if (sclk_m && !ps) begin rises++; cap = {cap[14:0], mosi_m}; end
         if (sclk_m !== ps) tog++;
         if (cs_m && sclk_m) bad++;
         if (!cs_m) cslow++;
         if (!ldac_m) ldacl++;
         if (busy_m !== ~rdy_m) bad++;
         ps = sclk_m;
         if (done_m) got = 1;
         else begin n++; @(negedge clk); end
      end
      chk({nm, " capture"}, {16'd0, cap}, {16'd0, v.w});
      chk({nm, " rises"}, rises, 16);
      chk({nm, " toggles"}, tog, 32);
      chk({nm, " cs_low"}, cslow, v.cs_low);
      chk({nm, " ldac_low"}, ldacl, 1);
      chk({nm, " done_at"}, got ? n : -1, v.done_at);
      chk({nm, " violations"}, bad, 0);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, " dut0"}, {25'd0, cs0, sclk0, mosi0, ldac0, rdy0, busy0, done0}, 32'b1001100);
      chk({nm, " dut1"}, {25'd0, cs1, sclk1, mosi1, ldac1, rdy1, busy1, done1}, 32'b1001100);
   endtask

   initial begin
      vecs[0] = mk(16'h3A5C, 0);
      vecs[1] = mk(16'h0FFF, 0);
      vecs[2] = mk(16'h8001, 0);
      vecs[3] = mk(16'h0000, 1);
      vecs[4] = mk(16'hFFFF, 1);
      vecs[5] = mk(16'($urandom), 0);
      vecs[6] = mk(16'($urandom), 0);
      vecs[7] = mk(16'($urandom), 1);
      vecs[8] = mk(16'($urandom), 1);

      // Reset asserted before any clock edge, with tx_valid held high.
      v0 = 1'b1; v1 = 1'b1;
      #1 reset = 1'b1;
      #1 chk_reset_vals("reset_async");
      repeat (3) @(posedge clk);
      #1 chk_reset_vals("reset_held_valid");
      @(negedge clk);
      v0 = 1'b0; v1 = 1'b0;
      reset = 1'b0;

      foreach (vecs[i]) send(vecs[i], $sformatf("vec%0d", i));

      // Back-to-back: tx_valid stays high, second word accepted in the done cycle.
      begin
         int n = 0, rises = 0, hi = 0, dones = 0, d1at = 0, d2at = 0;
         logic [31:0] cap = '0;
         logic ps = 1'b0;
         bit drop = 0;
         sel = 1'b0;
         v0 = 1'b1; {c0, d0} = 16'h3A5C;
         @(negedge clk);
         {c0, d0} = 16'h0FFF;
         while (dones < 2 && n < 700) begin
            if (drop) begin v0 = 1'b0; drop = 0; end
            if (sclk0 && !ps) begin rises++; cap = {cap[30:0], mosi0}; end
            ps = sclk0;
            if (cs0 && rises == 16) hi++;
            if (done0) begin
               dones++;
               if (dones == 1) begin d1at = n; drop = 1; end else d2at = n;
            end
            n++;
            if (dones < 2) @(negedge clk);
         end
         chk("b2b dones", dones, 2);
         chk("b2b capture1", cap[31:16], 16'h3A5C);
         chk("b2b capture2", cap[15:0], 16'h0FFF);
         chk("b2b cs_high_gap", hi, 3);
         chk("b2b period", d2at - d1at, 137);
         v0 = 1'b0;
         @(negedge clk);
      end

      // Request pulsed mid-frame is ignored.
      begin
         int dones = 0, falls = 0, rises = 0;
         logic [15:0] cap = '0;
         logic ps = 1'b0, pc = 1'b1;
         sel = 1'b0;
         v0 = 1'b1; {c0, d0} = 16'hC3A5;
         @(negedge clk);
         v0 = 1'b0;
         for (int n = 0; n < 300; n++) begin
            if (n == 50) begin v0 = 1'b1; {c0, d0} = 16'h1234; end
            if (n == 51) v0 = 1'b0;
            if (sclk0 && !ps) begin rises++; cap = {cap[14:0], mosi0}; end
            if (!cs0 && pc) falls++;
            if (done0) dones++;
            ps = sclk0; pc = cs0;
            @(negedge clk);
         end
         chk("ignore dones", dones, 1);
         chk("ignore cs_falls", falls, 1);
         chk("ignore rises", rises, 16);
         chk("ignore capture", {16'd0, cap}, 32'hC3A5);
      end

      // Reset mid-frame aborts it; next frame right after release is clean.
      begin
         int bad = 0;
         sel = 1'b0;
         v0 = 1'b1; {c0, d0} = 16'h5555;
         @(negedge clk);
         v0 = 1'b0;
         for (int n = 0; n < 60; n++) @(negedge clk);
         chk("abort midframe cs_n", {31'd0, cs0}, 32'd0);
         #2 reset = 1'b1;
         #1 chk_reset_vals("abort_async");
         for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (sclk0 || !ldac0 || done0 || !cs0) bad++;
         end
         reset = 1'b0;
         send(mk(16'h8001, 0), "post_abort");
         chk("abort quiet", bad, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
